// File: rtl/sdrc_wb_arb.sv
// Round-robin arbiter: four Wishbone masters share one slave port (wb2sdrc).
// Define SDRC_WB_ARB_TIMEOUT_EN to add the slave-ack timeout with m_err_o and the DRAIN state.
module sdrc_wb_arb #(
  parameter int dw = 32,
  parameter int AW = 30
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [3:0]            m_cyc_i,
  input  logic [3:0]            m_stb_i,
  input  logic [3:0]            m_we_i,
  input  logic [4*AW-1:0]       m_addr_i,
  input  logic [4*dw-1:0]       m_dat_i,
  input  logic [4*(dw/8)-1:0]   m_sel_i,
  input  logic [11:0]           m_cti_i,
  output logic [3:0]            m_ack_o,
  output logic [3:0]            m_err_o,
  output logic [dw-1:0]         m_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_addr_o,
  output logic [dw-1:0]         s_dat_o,
  output logic [dw/8-1:0]       s_sel_o,
  output logic [2:0]            s_cti_o,
  input  logic                  s_ack_i,
  input  logic [dw-1:0]         s_dat_i,
  output logic [3:0]            arb_gnt_o
);

  localparam int SW = dw / 8;

`ifdef SDRC_WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t     state_q;
  logic [3:0] gnt_q;
  // own_q is the granted master in GRANT/DRAIN and the last owner in IDLE
  logic [1:0] own_q;
  logic [1:0] pick_d;
  logic [1:0] cand;
  logic       found;

  logic [AW-1:0] addr_a [4];
  logic [dw-1:0] dat_a  [4];
  logic [SW-1:0] sel_a  [4];
  logic [2:0]    cti_a  [4];

  for (genvar n = 0; n < 4; n++) begin : g_m
    assign addr_a[n] = m_addr_i[n*AW +: AW];
    assign dat_a[n]  = m_dat_i[n*dw +: dw];
    assign sel_a[n]  = m_sel_i[n*SW +: SW];
    assign cti_a[n]  = m_cti_i[n*3 +: 3];
  end

  // search starts one past the last owner; i==4 wraps back to the last owner itself
  always_comb begin
    pick_d = own_q;
    found  = 1'b0;
    cand   = own_q;
    for (int i = 1; i <= 4; i++) begin
      cand = own_q + 2'(i);
      if (!found && m_cyc_i[cand]) begin
        pick_d = cand;
        found  = 1'b1;
      end
    end
  end

  assign s_cyc_o  = (state_q == GRANT) && m_cyc_i[own_q];
  assign s_stb_o  = (state_q == GRANT) && m_stb_i[own_q];
  assign s_we_o   = m_we_i[own_q];
  assign s_addr_o = addr_a[own_q];
  assign s_dat_o  = dat_a[own_q];
  assign s_sel_o  = sel_a[own_q];
  assign s_cti_o  = cti_a[own_q];
  assign m_ack_o  = ((state_q == GRANT) && s_ack_i) ? gnt_q : 4'b0000;
  assign m_dat_o  = s_dat_i;
  assign arb_gnt_o = gnt_q;

`ifdef SDRC_WB_ARB_TIMEOUT_EN
  logic [9:0] tmo_q;
  logic [3:0] err_q;
  assign m_err_o = err_q;
`else
  assign m_err_o = 4'b0000;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      own_q   <= 2'd3;
`ifdef SDRC_WB_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 4'b0000;
`endif
    end else begin
`ifdef SDRC_WB_ARB_TIMEOUT_EN
      err_q <= 4'b0000;
      if (state_q != GRANT || s_ack_i) tmo_q <= '0;
      else if (s_stb_o)                tmo_q <= tmo_q + 10'd1;
`endif
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            state_q <= GRANT;
            own_q   <= pick_d;
            gnt_q   <= 4'b0001 << pick_d;
          end
        end
        GRANT: begin
          if (!m_cyc_i[own_q]) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
          end
`ifdef SDRC_WB_ARB_TIMEOUT_EN
          else if (tmo_q == 10'h3ff && !s_ack_i) begin
            state_q <= DRAIN;
            err_q   <= gnt_q;
          end
        end
        DRAIN: begin
          if (!m_cyc_i[own_q]) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// Directed bench for sdrc_wb_arb: per-cycle vector table plus burst, reset and timeout sequences.
module tb_sdrc_wb_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cyc, stb, we;
  logic [119:0] addr;
  logic [127:0] mdat;
  logic [15:0]  sel;
  logic [11:0]  cti;
  logic [3:0]   mack, merr, gnt;
  logic [31:0]  mdo, sdo, sdat;
  logic         scyc, sstb, swe, ack;
  logic [29:0]  saddr;
  logic [3:0]   ssel;
  logic [2:0]   scti;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdrc_wb_arb #(.dw(32), .AW(30)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_addr_i(addr),
    .m_dat_i(mdat), .m_sel_i(sel), .m_cti_i(cti),
    .m_ack_o(mack), .m_err_o(merr), .m_dat_o(mdo),
    .s_cyc_o(scyc), .s_stb_o(sstb), .s_we_o(swe), .s_addr_o(saddr),
    .s_dat_o(sdo), .s_sel_o(ssel), .s_cti_o(scti),
    .s_ack_i(ack), .s_dat_i(sdat), .arb_gnt_o(gnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic        ack;
    logic [31:0] sdat;
    logic [3:0]  gnt;
    logic        scyc;
    logic [3:0]  mack;
    logic [29:0] addr;
  } vec_t;

  vec_t tv [24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_ack;
    int wait_cyc;
    // master n address: 0x10+n, except master 3 at 0x100
    addr = {30'h100, 30'h12, 30'h11, 30'h10};
    mdat = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    sel  = 16'hffff;
    we   = 4'b0111;
    cti  = 12'h000;
    rst = 1'b1; cyc = 4'b0; stb = 4'b0; ack = 1'b0; sdat = 32'h0;

    tv[0]  = '{1'b1, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 4'b0000, 30'h100};
    tv[1]  = '{1'b0, 4'b0101, 1'b0, 32'hF0F0F0F0, 4'b0001, 1'b1, 4'b0000, 30'h10};
    tv[2]  = '{1'b0, 4'b0101, 1'b1, 32'h1,        4'b0001, 1'b1, 4'b0001, 30'h10};
    tv[3]  = '{1'b0, 4'b0100, 1'b0, 32'h2,        4'b0000, 1'b0, 4'b0000, 30'h10};
    tv[4]  = '{1'b0, 4'b0100, 1'b0, 32'h3,        4'b0100, 1'b1, 4'b0000, 30'h12};
    tv[5]  = '{1'b0, 4'b0100, 1'b1, 32'h4,        4'b0100, 1'b1, 4'b0100, 30'h12};
    tv[6]  = '{1'b0, 4'b0000, 1'b0, 32'h5,        4'b0000, 1'b0, 4'b0000, 30'h12};
    tv[7]  = '{1'b1, 4'b1111, 1'b0, 32'h6,        4'b0000, 1'b0, 4'b0000, 30'h100};
    tv[8]  = '{1'b0, 4'b1111, 1'b1, 32'h7,        4'b0001, 1'b1, 4'b0001, 30'h10};
    tv[9]  = '{1'b0, 4'b1110, 1'b0, 32'h8,        4'b0000, 1'b0, 4'b0000, 30'h10};
    tv[10] = '{1'b0, 4'b1110, 1'b1, 32'h9,        4'b0010, 1'b1, 4'b0010, 30'h11};
    tv[11] = '{1'b0, 4'b1100, 1'b0, 32'hA,        4'b0000, 1'b0, 4'b0000, 30'h11};
    tv[12] = '{1'b0, 4'b1100, 1'b1, 32'hB,        4'b0100, 1'b1, 4'b0100, 30'h12};
    tv[13] = '{1'b0, 4'b1000, 1'b0, 32'hC,        4'b0000, 1'b0, 4'b0000, 30'h12};
    tv[14] = '{1'b0, 4'b1001, 1'b1, 32'hD,        4'b1000, 1'b1, 4'b1000, 30'h100};
    tv[15] = '{1'b0, 4'b0001, 1'b0, 32'hE,        4'b0000, 1'b0, 4'b0000, 30'h100};
    tv[16] = '{1'b0, 4'b0001, 1'b1, 32'hF,        4'b0001, 1'b1, 4'b0001, 30'h10};
    tv[17] = '{1'b0, 4'b0000, 1'b0, 32'h10,       4'b0000, 1'b0, 4'b0000, 30'h10};
    tv[18] = '{1'b0, 4'b1000, 1'b1, 32'hDEADBEEF, 4'b1000, 1'b1, 4'b1000, 30'h100};
    tv[19] = '{1'b0, 4'b0000, 1'b0, 32'h11,       4'b0000, 1'b0, 4'b0000, 30'h100};
    tv[20] = '{1'b0, 4'b0101, 1'b0, 32'h12,       4'b0001, 1'b1, 4'b0000, 30'h10};
    tv[21] = '{1'b0, 4'b0101, 1'b1, 32'h13,       4'b0001, 1'b1, 4'b0001, 30'h10};
    tv[22] = '{1'b0, 4'b0000, 1'b0, 32'h14,       4'b0000, 1'b0, 4'b0000, 30'h10};
    tv[23] = '{1'b0, 4'b0000, 1'b0, 32'h15,       4'b0000, 1'b0, 4'b0000, 30'h10};

    for (int k = 0; k < 24; k++) begin
      rst = tv[k].rst; cyc = tv[k].cyc; stb = tv[k].cyc;
      ack = tv[k].ack; sdat = tv[k].sdat;
      tick();
      chk($sformatf("v%0d gnt", k),  64'(gnt),   64'(tv[k].gnt));
      chk($sformatf("v%0d scyc", k), 64'(scyc),  64'(tv[k].scyc));
      chk($sformatf("v%0d sstb", k), 64'(sstb),  64'(tv[k].scyc));
      chk($sformatf("v%0d mack", k), 64'(mack),  64'(tv[k].mack));
      chk($sformatf("v%0d addr", k), 64'(saddr), 64'(tv[k].addr));
      chk($sformatf("v%0d mdat", k), 64'(mdo),   64'(tv[k].sdat));
      chk($sformatf("v%0d merr", k), 64'(merr),  64'd0);
    end

    // 8-beat burst from master 1 while master 2 waits
    rst = 1'b1; cyc = 4'b0000; stb = 4'b0000; ack = 1'b0;
    tick();
    rst = 1'b0; cyc = 4'b0110; stb = 4'b0110; cti = 12'h000; cti[5:3] = 3'b010;
    tick();
    chk("burst gnt", 64'(gnt), 64'h2);
    chk("burst wdat", 64'(sdo), 64'hA1A1A1A1);
    n_ack = 0;
    for (int b = 0; b < 8; b++) begin
      cti[5:3] = (b == 7) ? 3'b111 : 3'b010;
      ack = 1'b1;
      tick();
      if (mack == 4'b0010) n_ack++;
      chk($sformatf("burst b%0d mack", b), 64'(mack), 64'h2);
      chk($sformatf("burst b%0d gnt", b),  64'(gnt),  64'h2);
      chk($sformatf("burst b%0d cti", b),  64'(scti), (b == 7) ? 64'h7 : 64'h2);
    end
    chk("burst acks", 64'(n_ack), 64'd8);
    ack = 1'b0; cyc = 4'b0100; stb = 4'b0100;
    tick();
    chk("burst dead gnt", 64'(gnt), 64'h0);
    chk("burst dead scyc", 64'(scyc), 64'h0);
    tick();
    chk("burst next gnt", 64'(gnt), 64'h4);

    // reset in the middle of master 2's burst, master 0 also requesting
    cyc = 4'b0101; stb = 4'b0101; cti[8:6] = 3'b010; ack = 1'b1;
    tick();
    chk("rst pre mack", 64'(mack), 64'h4);
    rst = 1'b1;
    tick();
    chk("rst scyc", 64'(scyc), 64'h0);
    chk("rst gnt", 64'(gnt), 64'h0);
    chk("rst mack", 64'(mack), 64'h0);
    rst = 1'b0; ack = 1'b0;
    tick();
    chk("rst after gnt", 64'(gnt), 64'h1);

`ifdef SDRC_WB_ARB_TIMEOUT_EN
    // slave never acks: error pulse after 1023 stalled cycles
    rst = 1'b1; cyc = 4'b0000; stb = 4'b0000; ack = 1'b0;
    tick();
    rst = 1'b0; cyc = 4'b0001; stb = 4'b0001;
    tick();
    chk("tmo gnt", 64'(gnt), 64'h1);
    wait_cyc = 0;
    while (merr == 4'b0000 && wait_cyc < 2000) begin
      tick();
      wait_cyc++;
    end
    chk("tmo delay", 64'(wait_cyc), 64'd1024);
    chk("tmo merr", 64'(merr), 64'h1);
    chk("tmo scyc", 64'(scyc), 64'h0);
    tick();
    chk("tmo merr pulse", 64'(merr), 64'h0);
    chk("drain scyc", 64'(scyc), 64'h0);
    cyc = 4'b0000; stb = 4'b0000;
    tick();
    chk("drain exit gnt", 64'(gnt), 64'h0);
    cyc = 4'b0001; stb = 4'b0001;
    tick();
    chk("drain regrant", 64'(gnt), 64'h1);
    chk("drain regrant scyc", 64'(scyc), 64'h1);
`else
    wait_cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrc_wb_arb.md
SDRC_WB_ARB -- requirements
Module: sdrc_wb_arb

Interface
REQ-001 Parameter dw, default 32: Wishbone data width, shared by all masters and the slave port.
REQ-002 Parameter AW, default 30: Wishbone address width.
REQ-003 wb_clk_i  input  1  single clock; all logic is clocked on the rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-005 m_cyc_i  input  4  per-master cycle request; bit n belongs to master n.
REQ-006 m_stb_i  input  4  per-master strobe.
REQ-007 m_we_i  input  4  per-master write enable (1 = write).
REQ-008 m_addr_i  input  4*AW  per-master address; master n occupies slice [n*AW +: AW].
REQ-009 m_dat_i  input  4*dw  per-master write data.
REQ-010 m_sel_i  input  4*dw/8  per-master byte enables.
REQ-011 m_cti_i  input  12  per-master cycle type identifier, 3 bits per master.
REQ-012 m_ack_o  output  4  per-master acknowledge.
REQ-013 m_err_o  output  4  per-master timeout error pulse.
REQ-014 m_dat_o  output  dw  read data, broadcast to all masters.
REQ-015 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side controls toward wb2sdrc.
REQ-016 s_addr_o  output  AW; s_dat_o  output  dw; s_sel_o  output  dw/8; s_cti_o  output  3: muxed slave-side fields.
REQ-017 s_ack_i  input  1; s_dat_i  input  dw: slave acknowledge and read data.
REQ-018 arb_gnt_o  output  4  one-hot registered grant; all zeros when no master is granted.

Function
REQ-019 FSM states: IDLE, GRANT, DRAIN.
REQ-020 IDLE: if any m_cyc_i bit is high, the next edge selects one master round-robin, starting the search at (last_gnt+1) mod 4; arb_gnt_o is loaded and the FSM goes to GRANT.
REQ-021 Request-to-grant latency is exactly 1 cycle: m_cyc_i is seen high at edge N, and s_cyc_o is high in the cycle after edge N.
REQ-022 GRANT: the s_* fields are a combinational mux of the granted master's inputs; s_cyc_o and s_stb_o follow the granted master's m_cyc_i and m_stb_i.
REQ-023 GRANT: m_ack_o[g] = s_ack_i for the granted master g; every other bit of m_ack_o and m_err_o is 0.
REQ-024 m_dat_o = s_dat_i at all times.
REQ-025 The grant is never pre-empted; burst cycles (cti 3'b010) are held until the granted master drops m_cyc_i.
REQ-026 GRANT with the granted m_cyc_i low: the next edge sets last_gnt <= g, clears arb_gnt_o and goes to IDLE, giving one dead cycle between owners.
REQ-027 IDLE: s_cyc_o = s_stb_o = 0 and m_ack_o = 0; the other s_* fields hold the mux of master last_gnt.
REQ-028 A requester that drops m_cyc_i before being granted is ignored; there is no request latching.
REQ-029 Simultaneous requests resolve purely by round-robin order, so each requester waits at most 3 grants.
REQ-030 DRAIN exists only with the timeout feature; see REQ-036.

Reset
REQ-031 On wb_rst_i high at a clock edge: FSM = IDLE, arb_gnt_o = 0, last_gnt = 3 (so master 0 wins first), and the timeout counter = 0.
REQ-032 Resulting outputs: s_cyc_o = s_stb_o = 0, m_ack_o = 0, m_err_o = 0.
REQ-033 Reset asserted mid-cycle drops s_cyc_o in the cycle after the edge, regardless of an outstanding ack.

Configuration
REQ-034 Macro SDRC_WB_ARB_TIMEOUT_EN controls the slave-ack timeout.
REQ-035 When defined: a 10-bit counter increments each GRANT cycle with s_stb_o=1 and s_ack_i=0; it clears on s_ack_i, in IDLE, and on reset.
REQ-036 When defined and the counter reaches 1023: the next edge pulses m_err_o[g] for 1 cycle, forces s_cyc_o = s_stb_o = 0, and enters DRAIN.
REQ-037 DRAIN: no slave access and no acks; the FSM stays until m_cyc_i[g] is low, then sets last_gnt <= g and returns to IDLE.
REQ-038 When undefined: no counter and no DRAIN state; m_err_o is tied to 0.

Verification
REQ-039 Reset, then m_cyc_i=4'b0101 -> arb_gnt_o=4'b0001 one cycle later; after master 0 releases: 1 dead cycle, then arb_gnt_o=4'b0100.
REQ-040 All four masters request continuously, 1 single write each -> grant order 0,1,2,3,0; m_ack_o only ever reaches the granted master.
REQ-041 Master 1 runs an 8-beat burst (cti 010, last beat 111) while master 2 requests -> 8 acks to master 1 only; master 2 is granted only after master 1 drops m_cyc_i.
REQ-042 Master 3 reads 0x0000_0100 with slave data 32'hDEADBEEF -> s_addr_o=30'h100 and m_dat_o=32'hDEADBEEF with m_ack_o=4'b1000.
REQ-043 wb_rst_i pulsed during master 2's burst -> next cycle s_cyc_o=0 and arb_gnt_o=0; a following request from master 2 sees master 0 served first if master 0 is also requesting.
REQ-044 With SDRC_WB_ARB_TIMEOUT_EN and s_ack_i held low -> m_err_o[g] pulses after 1023 stalled cycles and s_cyc_o drops; the FSM returns to IDLE once the master releases m_cyc_i.
